mem_access_unit: RTL and testbench

- Load/store front-end between the MIPS datapath memory stage and the 1024x32 word-addressed data RAM.
- Accepts one byte-addressed request at a time: LW, LH, LHU, LB, LBU, SW, SH or SB.
- Drives the RAM's clk-sampled write port. Sub-word stores are done as read-modify-write. Loads are returned sign- or zero-extended with a one-cycle done pulse.

---
 rtl/mem_access_unit_if.sv | 41 ++++
 rtl/mem_access_unit.sv | 181 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_if
//   Bundles the memory-stage request/response handshake and the data RAM
//   port of the load/store unit.
//
//   Request side : req_valid, req_ready, req_op, req_addr, req_wdata
//   Response side: done, err, rdata
//   RAM side     : ram_we, ram_addr, ram_din, ram_dout
//
//   Modports:
//     slave  - the load/store unit. It receives requests and drives the RAM.
//     master - the environment: the datapath plus the RAM.
// -----------------------------------------------------------------------------
interface mem_access_unit_if #(
  parameter int ADDR_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              done;
  logic              err;
  logic [31:0]       rdata;

  logic              ram_we;
  logic [ADDR_W-3:0] ram_addr;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, ram_dout,
    output req_ready, done, err, rdata, ram_we, ram_addr, ram_din
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, ram_dout,
    input  req_ready, done, err, rdata, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   Load/store front-end between the MIPS memory stage and a 1024x32
//   word-addressed data RAM. The unit takes one byte-addressed request at a
//   time (LW/LH/LHU/LB/LBU/SW/SH/SB). Sub-word stores are done as
//   read-modify-write. Load results are sign- or zero-extended and signalled
//   with a one-cycle done pulse.
//
//   Parameters:
//     ADDR_W     - byte address width. The RAM word address is ADDR_W-2 bits.
//     BIG_ENDIAN - 1: byte offset 0 is bits 31:24 (MIPS).
//                  0: byte offset 0 is bits 7:0.
//
//   Ports:
//     clk   - system clock, rising edge
//     reset - asynchronous, active-high reset
//     bus   - mem_access_unit_if.slave (request, response and RAM signals)
//
//   Latency, counted inclusively from the accept edge to the edge that ends
//   done:
//     misaligned 2, loads 3, SW 3, SH/SB 4.
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int ADDR_W     = 12,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input logic              clk,
  input logic              reset,
  mem_access_unit_if.slave bus
);

  localparam int WA_W = ADDR_W - 2;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e            state;
  state_e            state_nxt;

  op_e               op_q;
  logic [1:0]        off_q;
  logic [15:0]       wdata_q;
  logic              err_q;
  logic [31:0]       rdata_q;
  logic [WA_W-1:0]   ram_addr_q;
  logic [31:0]       ram_din_q;

  op_e               req_op;
  logic              misaligned;
  logic              is_load;
  logic [1:0]        byte_lane;
  logic              half_lane;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       load_ext;
  logic [31:0]       merged;

  assign req_op  = op_e'(bus.req_op);
  assign is_load = (op_q != OP_SW) && (op_q != OP_SH) && (op_q != OP_SB);

  // Alignment check on the incoming request. SB, LB and LBU are never
  // misaligned.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first.
    // Otherwise a path that does not assign it would infer a latch.
    misaligned = 1'b0;
    case (req_op)
      OP_LW, OP_SW:          misaligned = |bus.req_addr[1:0];
      OP_LH, OP_LHU, OP_SH:  misaligned = bus.req_addr[0];
      default:               misaligned = 1'b0;
    endcase
  end

  // Map the byte offset to a bit lane. In big-endian order offset 0 is the
  // most significant byte, so the lane index is the inverted offset.
  assign byte_lane = BIG_ENDIAN ? ~off_q : off_q;
  assign half_lane = BIG_ENDIAN ? ~off_q[1] : off_q[1];
  assign ld_byte   = bus.ram_dout[{byte_lane, 3'b000} +: 8];
  assign ld_half   = bus.ram_dout[{half_lane, 4'b0000} +: 16];

  // Extend the extracted load data, and merge store data into the word
  // read from the RAM.
  always_comb begin
    load_ext = bus.ram_dout;
    merged   = bus.ram_dout;
    case (op_q)
      OP_LH:   load_ext = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  load_ext = {16'h0000, ld_half};
      OP_LB:   load_ext = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  load_ext = {24'h000000, ld_byte};
      OP_SH:   merged[{half_lane, 4'b0000} +: 16] = wdata_q;
      OP_SB:   merged[{byte_lane, 3'b000} +: 8]   = wdata_q[7:0];
      default: load_ext = bus.ram_dout;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (misaligned)           state_nxt = RESP;
          else if (req_op == OP_SW) state_nxt = WRITE;
          else                      state_nxt = READ;
        end
      end
      READ:    state_nxt = is_load ? RESP : WRITE;
      WRITE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every
  // register then updates from values sampled before the edge, regardless
  // of the order of the processes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Request capture and the data path registers. A reset clears them
  // asynchronously. The state register also drops to IDLE, so a pending
  // write is abandoned before its closing edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q       <= OP_LW;
      off_q      <= 2'b00;
      wdata_q    <= 16'h0000;
      err_q      <= 1'b0;
      rdata_q    <= 32'h0000_0000;
      ram_addr_q <= '0;
      ram_din_q  <= 32'h0000_0000;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op_q       <= req_op;
            off_q      <= bus.req_addr[1:0];
            wdata_q    <= bus.req_wdata[15:0];
            err_q      <= misaligned;
            ram_addr_q <= bus.req_addr[ADDR_W-1:2];
            if (req_op == OP_SW && !misaligned) ram_din_q <= bus.req_wdata;
          end
        end
        READ: begin
          if (is_load) rdata_q   <= load_ext;
          else         ram_din_q <= merged;
        end
        default: ;
      endcase
    end
  end

  // ram_we depends only on the registered state. A change on the request
  // inputs cannot start a write without a clock edge.
  assign bus.req_ready = (state == IDLE);
  assign bus.done      = (state == RESP);
  assign bus.err       = (state == RESP) && err_q;
  assign bus.rdata     = rdata_q;
  assign bus.ram_we    = (state == WRITE);
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_din   = ram_din_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//   Directed testbench for mem_access_unit (ADDR_W=12, big-endian). A
//   1024x32 RAM model sits on the RAM side of the interface. The RAM read
//   path is combinational and the write commits on the rising edge.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam int ADDR_W = 12;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

  mem_access_unit #(.ADDR_W(ADDR_W), .BIG_ENDIAN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [1024];
  int          we_count = 0;
  logic [9:0]  last_we_addr = '0;
  int          tests = 0;
  int          failed = 0;

  assign bus.ram_dout = mem[bus.ram_addr];

  always @(posedge clk) begin
    if (bus.ram_we === 1'b1) begin
      mem[bus.ram_addr] <= bus.ram_din;
      we_count++;
      last_we_addr = bus.ram_addr;
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] <= 32'h0000_0000;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one request at a negedge. Then count rising edges, starting with
  // the accept edge, up to and including the edge that ends the done pulse.
  // With hold=1, req_valid stays high with a different request until done
  // shows. That request must be ignored.
  task automatic do_req(input logic [2:0] op, input logic [11:0] addr,
                        input logic [31:0] wdata, input bit hold,
                        output int lat, output logic err_o,
                        output logic [31:0] rdata_o);
    bit seen;
    bit fin;
    lat = 0; seen = 1'b0; fin = 1'b0; err_o = 1'bx; rdata_o = 'x;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = addr; bus.req_wdata = wdata;
    for (int i = 0; i < 12 && !fin; i++) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        if (hold) begin
          bus.req_op = OP_SW; bus.req_addr = 12'h000; bus.req_wdata = 32'hBAD0_BAD0;
        end else begin
          bus.req_valid = 1'b0;
        end
      end
      if (!seen && bus.done === 1'b1) begin
        seen = 1'b1; err_o = bus.err; rdata_o = bus.rdata; bus.req_valid = 1'b0;
      end else if (seen && bus.done === 1'b0) begin
        fin = 1'b1;
      end
    end
    bus.req_valid = 1'b0;
    tests++;
    if (!fin) begin
      failed++;
      $display("FAIL req_timeout: op %0d addr %h got no complete done pulse, required one within 12 cycles", op, addr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (bus.req_ready !== 1'b1) begin failed++; $display("FAIL reset_ready: got %b required 1", bus.req_ready); end
    tests++; if (bus.done !== 1'b0) begin failed++; $display("FAIL reset_done: got %b required 0", bus.done); end
    tests++; if (bus.err !== 1'b0) begin failed++; $display("FAIL reset_err: got %b required 0", bus.err); end
    tests++; if (bus.rdata !== 32'h0) begin failed++; $display("FAIL reset_rdata: got %h required 0", bus.rdata); end
    tests++; if (bus.ram_we !== 1'b0) begin failed++; $display("FAIL reset_we: got %b required 0", bus.ram_we); end
    tests++; if (bus.ram_addr !== 10'h0) begin failed++; $display("FAIL reset_addr: got %h required 0", bus.ram_addr); end
    tests++; if (bus.ram_din !== 32'h0) begin failed++; $display("FAIL reset_din: got %h required 0", bus.ram_din); end
    reset = 1'b0;
  endtask

  task automatic test_sw_lw();
    int lat; logic e; logic [31:0] r; int base;
    base = we_count;
    do_req(OP_SW, 12'h010, 32'hDEAD_BEEF, 1'b0, lat, e, r);
    tests++; if (lat !== 3) begin failed++; $display("FAIL sw_latency: got %0d required 3", lat); end
    tests++; if (e !== 1'b0) begin failed++; $display("FAIL sw_err: got %b required 0", e); end
    tests++; if (we_count - base !== 1) begin failed++; $display("FAIL sw_we_cycles: got %0d required 1", we_count - base); end
    tests++; if (last_we_addr !== 10'd4) begin failed++; $display("FAIL sw_ram_addr: got %0d required 4", last_we_addr); end
    base = we_count;
    do_req(OP_LW, 12'h010, 32'h0, 1'b0, lat, e, r);
    tests++; if (r !== 32'hDEAD_BEEF) begin failed++; $display("FAIL lw_rdata: got %h required deadbeef", r); end
    tests++; if (e !== 1'b0) begin failed++; $display("FAIL lw_err: got %b required 0", e); end
    tests++; if (lat !== 3) begin failed++; $display("FAIL lw_latency: got %0d required 3", lat); end
    tests++; if (we_count !== base) begin failed++; $display("FAIL lw_no_write: got %0d writes required 0", we_count - base); end
  endtask

  task automatic test_sb();
    int lat; logic e; logic [31:0] r; int base;
    base = we_count;
    do_req(OP_SB, 12'h011, 32'hAAAA_AA55, 1'b0, lat, e, r);
    tests++; if (lat !== 4) begin failed++; $display("FAIL sb_latency: got %0d required 4", lat); end
    tests++; if (we_count - base !== 1) begin failed++; $display("FAIL sb_we_cycles: got %0d required 1", we_count - base); end
    tests++; if (e !== 1'b0) begin failed++; $display("FAIL sb_err: got %b required 0", e); end
    do_req(OP_LW, 12'h010, 32'h0, 1'b0, lat, e, r);
    tests++; if (r !== 32'hDE55_BEEF) begin failed++; $display("FAIL sb_merge: got %h required de55beef", r); end
  endtask

  task automatic test_subword_loads();
    logic [2:0]  ops  [4] = '{OP_LB, OP_LBU, OP_LH, OP_LHU};
    logic [11:0] adrs [4] = '{12'h012, 12'h012, 12'h012, 12'h010};
    logic [31:0] exps [4] = '{32'hFFFF_FFBE, 32'h0000_00BE, 32'hFFFF_BEEF, 32'h0000_DE55};
    int lat; logic e; logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      do_req(ops[i], adrs[i], 32'h0, 1'b0, lat, e, r);
      tests++;
      if (r !== exps[i] || e !== 1'b0 || lat !== 3) begin
        failed++;
        $display("FAIL subword_load_%0d: got rdata %h err %b lat %0d required %h 0 3", i, r, e, lat, exps[i]);
      end
    end
  endtask

  task automatic test_misaligned();
    logic [2:0]  ops  [3] = '{OP_LW, OP_SH, OP_LH};
    logic [11:0] adrs [3] = '{12'h013, 12'h011, 12'h001};
    int lat; logic e; logic [31:0] r; int base;
    for (int i = 0; i < 3; i++) begin
      base = we_count;
      do_req(ops[i], adrs[i], 32'h7777_7777, 1'b0, lat, e, r);
      tests++;
      if (e !== 1'b1 || lat !== 2 || we_count !== base || r !== 32'h0000_DE55) begin
        failed++;
        $display("FAIL misaligned_%0d: got err %b lat %0d writes %0d rdata %h required 1 2 0 0000de55",
                 i, e, lat, we_count - base, r);
      end
    end
    tests++; if (mem[4] !== 32'hDE55_BEEF) begin failed++; $display("FAIL misaligned_mem4: got %h required de55beef", mem[4]); end
    tests++; if (mem[0] !== 32'h0) begin failed++; $display("FAIL misaligned_mem0: got %h required 0", mem[0]); end
  endtask

  task automatic test_sh();
    int lat; logic e; logic [31:0] r; int base;
    do_req(OP_SW, 12'h030, 32'hCAFE_F00D, 1'b0, lat, e, r);
    base = we_count;
    do_req(OP_SH, 12'h032, 32'hFFFF_1234, 1'b0, lat, e, r);
    tests++; if (lat !== 4 || we_count - base !== 1) begin failed++; $display("FAIL sh_timing: got lat %0d writes %0d required 4 1", lat, we_count - base); end
    do_req(OP_LW, 12'h030, 32'h0, 1'b0, lat, e, r);
    tests++; if (r !== 32'hCAFE_1234) begin failed++; $display("FAIL sh_merge: got %h required cafe1234", r); end
  endtask

  task automatic test_reset_abort();
    int lat; logic e; logic [31:0] r; int base; bit got_we;
    do_req(OP_SW, 12'h020, 32'h1122_3344, 1'b0, lat, e, r);
    base = we_count; got_we = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = OP_SH; bus.req_addr = 12'h022; bus.req_wdata = 32'h0000_AAAA;
    for (int i = 0; i < 8 && !got_we; i++) begin
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      if (bus.ram_we === 1'b1) got_we = 1'b1;
    end
    tests++; if (!got_we) begin failed++; $display("FAIL abort_we_seen: got no write cycle, required one within 8 cycles"); end
    #2 reset = 1'b1;
    #1;
    tests++; if (bus.ram_we !== 1'b0) begin failed++; $display("FAIL abort_we_drop: got %b required 0", bus.ram_we); end
    tests++;
    if (bus.req_ready !== 1'b1 || bus.done !== 1'b0 || bus.err !== 1'b0 || bus.rdata !== 32'h0 ||
        bus.ram_addr !== 10'h0 || bus.ram_din !== 32'h0) begin
      failed++;
      $display("FAIL abort_outputs: got ready %b done %b err %b rdata %h addr %h din %h required 1 0 0 0 0 0",
               bus.req_ready, bus.done, bus.err, bus.rdata, bus.ram_addr, bus.ram_din);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tests++; if (mem[8] !== 32'h1122_3344 || we_count !== base) begin failed++; $display("FAIL abort_mem: got %h writes %0d required 11223344 0", mem[8], we_count - base); end
    do_req(OP_LW, 12'h020, 32'h0, 1'b0, lat, e, r);
    tests++; if (r !== 32'h1122_3344 || lat !== 3) begin failed++; $display("FAIL abort_recover: got %h lat %0d required 11223344 3", r, lat); end
  endtask

  task automatic test_top_addr();
    int lat; logic e; logic [31:0] r;
    do_req(OP_SW, 12'hFFC, 32'h1234_5678, 1'b0, lat, e, r);
    tests++; if (last_we_addr !== 10'd1023) begin failed++; $display("FAIL top_ram_addr: got %0d required 1023", last_we_addr); end
    do_req(OP_LW, 12'hFFC, 32'h0, 1'b0, lat, e, r);
    tests++; if (r !== 32'h1234_5678) begin failed++; $display("FAIL top_rdata: got %h required 12345678", r); end
  endtask

  task automatic test_back_to_back();
    int lat; logic e; logic [31:0] r; int base;
    base = we_count;
    do_req(OP_LW, 12'hFFC, 32'h0, 1'b1, lat, e, r);
    tests++; if (r !== 32'h1234_5678 || lat !== 3 || we_count !== base) begin failed++; $display("FAIL hold_load: got %h lat %0d writes %0d required 12345678 3 0", r, lat, we_count - base); end
    do_req(OP_SB, 12'hFFF, 32'h0000_009A, 1'b1, lat, e, r);
    tests++; if (lat !== 4 || we_count - base !== 1) begin failed++; $display("FAIL hold_store: got lat %0d writes %0d required 4 1", lat, we_count - base); end
    do_req(OP_LW, 12'hFFC, 32'h0, 1'b0, lat, e, r);
    tests++; if (r !== 32'h1234_569A) begin failed++; $display("FAIL hold_sb_merge: got %h required 1234569a", r); end
    tests++; if (mem[0] !== 32'h0) begin failed++; $display("FAIL hold_ignored: got mem0 %h required 0", mem[0]); end
  endtask

  initial begin
    test_reset();
    test_sw_lw();
    test_sb();
    test_subword_loads();
    test_misaligned();
    test_sh();
    test_reset_abort();
    test_top_addr();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
